// File: rtl/serial_ge_compare_if.sv
// rtl/serial_ge_compare_if.sv - request/response bundle for serial_ge_compare
interface serial_ge_compare_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] c;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, c
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, c
   );
endinterface

// File: rtl/serial_ge_compare.sv
// rtl/serial_ge_compare.sv - byte-serial EQ/NE/GE/GEU comparator; SERIAL_CMP_EARLY_EXIT_EN enables early exit
module serial_ge_compare (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_ge_compare_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [1:0]  op_q;
   logic [2:0]  idx;
   logic        c_q;

   logic [7:0]  byte_a;
   logic [7:0]  byte_b;
   logic        byte_ne;
   logic        byte_gt;
   logic        accept;
   logic        finish;
   logic        res_eq;
   logic        res_gt;
   logic        flag;
   logic [63:0] sign_flip;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
   // First differing byte seen so far; later bytes must not override it.
   logic        found_q;
   logic        gt_q;
`endif

   assign byte_a  = a_q[{idx, 3'b000} +: 8];
   assign byte_b  = b_q[{idx, 3'b000} +: 8];
   assign byte_ne = (byte_a != byte_b);
   assign byte_gt = (byte_a > byte_b);

   // Flipping the sign bit of both operands maps signed order onto unsigned order.
   assign sign_flip = {(bus.op == 2'b10), 63'b0};

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.c         = {63'b0, c_q};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the scan verdict for the byte under the index.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      res_eq    = 1'b0;
      res_gt    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (byte_ne) begin
               finish = 1'b1;
               res_gt = byte_gt;
            end else if (idx == 3'd0) begin
               finish = 1'b1;
               res_eq = 1'b1;
            end
`else
            if (idx == 3'd0) begin
               finish = 1'b1;
               res_eq = !found_q && !byte_ne;
               res_gt = found_q ? gt_q : byte_gt;
            end
`endif
            if (finish) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Map the eq/gt verdict onto the requested relation.
   always_comb begin
      flag = 1'b0;
      case (op_q)
         2'b00:   flag = res_eq;
         2'b01:   flag = !res_eq;
         default: flag = res_gt | res_eq;
      endcase
   end

   // Operand latch, byte index and result flag; c drops back to 0 with out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= 64'b0;
         b_q     <= 64'b0;
         op_q    <= 2'b00;
         idx     <= 3'd7;
         c_q     <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
         found_q <= 1'b0;
         gt_q    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            a_q     <= bus.a ^ sign_flip;
            b_q     <= bus.b ^ sign_flip;
            op_q    <= bus.op;
            idx     <= 3'd7;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            found_q <= 1'b0;
            gt_q    <= 1'b0;
`endif
         end else if (state == SCAN && !finish) begin
            idx <= idx - 3'd1;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            if (!found_q && byte_ne) begin
               found_q <= 1'b1;
               gt_q    <= byte_gt;
            end
`endif
         end
         if (state == SCAN && finish) begin
            c_q <= flag;
         end else if (state == DONE && bus.out_ready) begin
            c_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_ge_compare.sv
// tb/tb_serial_ge_compare.sv - scoreboard bench for serial_ge_compare
module tb_serial_ge_compare;

   logic clk;
   logic rst_n;
   serial_ge_compare_if bus ();

   serial_ge_compare dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic c;
      int   lat;
      int   acc;
   } exp_t;

   exp_t        q[$];
   int          checks;
   int          errors;
   int          cyc;
   int          last_hs;
   int          last_acc;
   int          rel_cyc;
   logic        prev_valid;
   logic        rdy_mode;
   logic        rdy_val;
   logic        pend_c;
   int          pend_lat;
   logic [63:0] ext[5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer: out_ready either forced or randomised, applied just after the edge.
   always @(posedge clk) begin
      #2;
      bus.out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic ref_rel(input logic [63:0] x, input logic [63:0] y, input logic [1:0] o);
      case (o)
         2'b00:   return x == y;
         2'b01:   return x != y;
         2'b10:   return $signed(x) >= $signed(y);
         default: return x >= y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [63:0] x, input logic [63:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      logic [63:0] d;
      d = x ^ y;
      for (int i = 7; i >= 0; i--) begin
         if (((d >> (8 * i)) & 64'hFF) != 64'h0) return 8 - i;
      end
      return 8;
`else
      return 8;
`endif
   endfunction

   function automatic logic [63:0] rand_a();
      case ($urandom_range(0, 3))
         0:       return ext[$urandom_range(0, 4)];
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [63:0] rand_b(input logic [63:0] x);
      logic [63:0] m;
      case ($urandom_range(0, 4))
         0: return ext[$urandom_range(0, 4)];
         1: return {$urandom, $urandom};
         2: return x;
         default: begin
            m = 64'($urandom_range(0, 255)) << (8 * $urandom_range(0, 7));
            return x ^ m;
         end
      endcase
   endfunction

   // Call at posedge+1: present a request with its expected flag.
   task automatic present(input logic [63:0] x, input logic [63:0] y, input logic [1:0] o, input logic e);
      bus.in_valid = 1'b1;
      bus.a        = x;
      bus.b        = y;
      bus.op       = o;
      pend_c       = e;
      pend_lat     = ref_lat(x, y);
   endtask

   // Wait for acceptance; returns at posedge+1 after the accepting edge.
   task automatic wait_accept();
      exp_t e;
      logic got;
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.c      = pend_c;
            e.lat    = pend_lat;
            e.acc    = cyc + 1;
            last_acc = cyc + 1;
            q.push_back(e);
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=none expected=accept");
      end
      bus.in_valid = 1'b0;
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      bus.op       = 2'($urandom_range(0, 3));
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_valid actual=1 expected=0 at cycle %0d", cyc);
            end else begin
               if (!prev_valid) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
               chk("c_value", bus.c, {63'b0, q[0].c});
               chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
               if (bus.out_ready) begin
                  last_hs = cyc + 1;
                  void'(q.pop_front());
               end
            end
         end else begin
            chk("c_idle_zero", bus.c, 64'd0);
         end
      end
      prev_valid = bus.out_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] x;
      logic [63:0] y;
      logic [1:0]  o;
      logic        seen;
      ext[0] = 64'h0;
      ext[1] = 64'h1;
      ext[2] = 64'h7FFF_FFFF_FFFF_FFFF;
      ext[3] = 64'h8000_0000_0000_0000;
      ext[4] = 64'hFFFF_FFFF_FFFF_FFFF;
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      last_hs      = 0;
      last_acc     = 0;
      prev_valid   = 1'b0;
      rdy_mode     = 1'b0;
      rdy_val      = 1'b1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = 64'h0;
      bus.b        = 64'h0;
      bus.op       = 2'b00;
      bus.out_ready = 1'b1;

      // Reset held with a request pending.
      repeat (3) @(posedge clk);
      #1;
      present(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_c", bus.c, 64'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_accept();
      chk("first_accept_edge", 64'(last_acc), 64'(rel_cyc + 1));

      // Directed relations.
      present(64'h8000_0000_0000_0000, 64'h1, 2'b11, 1'b1);
      wait_accept();
      present(64'h8000_0000_0000_0000, 64'h1, 2'b10, 1'b0);
      wait_accept();
      present(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2'b10, 1'b1);
      wait_accept();
      present(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEE, 2'b01, 1'b1);
      wait_accept();
      present(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b1);
      wait_accept();
      present(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b11, 1'b0);
      wait_accept();
      drain();

      // Reset during SCAN aborts the operation.
      present(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);
      wait_accept();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      #3;
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Backpressure: result held, second request waits for the handshake.
      rdy_val = 1'b0;
      present(64'h8000_0000_0000_0000, 64'h1, 2'b11, 1'b1);
      wait_accept();
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = bus.out_valid;
      end
      chk("bp_valid_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      x = 64'hFFFF_FFFF_FFFF_FFFF;
      y = 64'h0;
      present(x, y, 2'b10, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      rdy_val = 1'b1;
      wait_accept();
      chk("bp_accept_after_hs", 64'(last_acc), 64'(last_hs + 1));
      drain();

      // Random back-to-back traffic with random consumer stalls.
      rdy_mode = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         x = rand_a();
         y = rand_b(x);
         o = 2'($urandom_range(0, 3));
         present(x, y, o, ref_rel(x, y, o));
         wait_accept();
      end
      rdy_mode = 1'b0;
      rdy_val  = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
